// File: rtl/counter_pkg.sv
// Shared types and constants for the counter sequencer and its datapath.
package counter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage : counter_pkg

// File: rtl/counter_core.sv
// Synchronous up/down counter; priority clr > load > en.
module counter_core
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic             en,
   input  logic             dir,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst)       q <= '0;
      else if (clr)  q <= '0;
      else if (load) q <= d;
      else if (en)   q <= (dir == DIR_DOWN) ? q - WIDTH'(1) : q + WIDTH'(1);
   end

endmodule : counter_core

// File: rtl/counter_seq_ctrl.sv
// Run sequencer for counter_core: one-shot / auto-reload runs with start, pause and stop.
module counter_seq_ctrl
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             dir,
   input  logic             auto_reload,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tc,
   output logic             done
);

   state_t           state, state_n;
   logic             dir_q, ar_q;
   logic [WIDTH-1:0] lv_q;
   logic [WIDTH-1:0] term_c;
   logic [WIDTH-1:0] core_d_c;
   logic             clr_c, load_c, en_c, latch_c, done_n;

   // Terminal follows the latched direction, so mid-run dir changes are harmless.
   assign term_c = (dir_q == DIR_DOWN) ? '0 : '1;
   assign tc     = (state == RUN) && !pause && (count == term_c);
   assign busy   = (state == RUN) || (state == PAUSED);

   // A fresh start loads the live port value; a reload uses the latched copy.
   assign core_d_c = latch_c ? load_val : lv_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         dir_q <= 1'b0;
         ar_q  <= 1'b0;
         lv_q  <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         done  <= done_n;
         if (latch_c) begin
            dir_q <= dir;
            ar_q  <= auto_reload;
            lv_q  <= load_val;
         end
      end
   end

   always_comb begin
      state_n = state;
      clr_c   = 1'b0;
      load_c  = 1'b0;
      en_c    = 1'b0;
      latch_c = 1'b0;
      done_n  = 1'b0;
      if (stop) begin
         state_n = IDLE;
         clr_c   = 1'b1;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  latch_c = 1'b1;
                  load_c  = 1'b1;
                  state_n = RUN;
               end
            end
            RUN: begin
               if (pause) begin
                  state_n = PAUSED;
               end else if (tc) begin
                  done_n = 1'b1;
                  if (ar_q) load_c  = 1'b1;
                  else      state_n = DONE;
               end else begin
                  en_c = 1'b1;
               end
            end
            PAUSED: begin
               if (!pause) state_n = RUN;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   counter_core #(.WIDTH(WIDTH)) u_core (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr_c),
      .load (load_c),
      .en   (en_c),
      .dir  (dir_q),
      .d    (core_d_c),
      .q    (count)
   );

endmodule : counter_seq_ctrl

// File: tb/tb_counter_seq_ctrl.sv
// Directed self-checking bench for counter_seq_ctrl (WIDTH=4).
module tb_counter_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, stop, pause, dir, auto_reload;
   logic [3:0] load_val;
   logic [3:0] count;
   logic       busy, tc, done;

   int n_cmp = 0;
   int n_bad = 0;

   counter_seq_ctrl #(.WIDTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .pause       (pause),
      .dir         (dir),
      .auto_reload (auto_reload),
      .load_val    (load_val),
      .count       (count),
      .busy        (busy),
      .tc          (tc),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check count/busy/tc/done together against hand-computed values.
   task automatic chk_all(input string tag, input int c, input int b, input int t, input int d);
      chk({tag, ".count"}, 8'(count), 8'(c));
      chk({tag, ".busy"},  8'(busy),  8'(b));
      chk({tag, ".tc"},    8'(tc),    8'(t));
      chk({tag, ".done"},  8'(done),  8'(d));
   endtask

   task automatic go(input logic [3:0] lv, input logic d, input logic ar);
      load_val = lv; dir = d; auto_reload = ar; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
      dir = 1'b0; auto_reload = 1'b0; load_val = 4'd0;
      tick(); tick();
      rst = 1'b0;
      chk_all("reset", 0, 0, 0, 0);

      // 1: reset mid-run
      go(4'd5, 1'b1, 1'b0);  chk_all("t1.c1", 5, 1, 0, 0);
      tick();                chk_all("t1.c2", 4, 1, 0, 0);
      rst = 1'b1; tick(); tick();
      rst = 1'b0;            chk_all("t1.rst", 0, 0, 0, 0);
      tick();                chk_all("t1.idle", 0, 0, 0, 0);

      // 2: one-shot down from 3
      go(4'd3, 1'b1, 1'b0);  chk_all("t2.c1", 3, 1, 0, 0);
      load_val = 4'd9; dir = 1'b0;
      tick();                chk_all("t2.c2", 2, 1, 0, 0);
      tick();                chk_all("t2.c3", 1, 1, 0, 0);
      tick();                chk_all("t2.c4", 0, 1, 1, 0);
      tick();                chk_all("t2.c5", 0, 0, 0, 1);
      tick();                chk_all("t2.c6", 0, 0, 0, 0);

      // 3: auto-reload up from 13
      go(4'd13, 1'b0, 1'b1); chk_all("t3.a", 13, 1, 0, 0);
      auto_reload = 1'b0; load_val = 4'd2;
      tick();                chk_all("t3.b", 14, 1, 0, 0);
      tick();                chk_all("t3.c", 15, 1, 1, 0);
      tick();                chk_all("t3.d", 13, 1, 0, 1);
      tick();                chk_all("t3.e", 14, 1, 0, 0);
      tick();                chk_all("t3.f", 15, 1, 1, 0);
      tick();                chk_all("t3.g", 13, 1, 0, 1);
      stop = 1'b1; tick(); stop = 1'b0;
                             chk_all("t3.stop", 0, 0, 0, 0);

      // 4: pause for 4 cycles at count 3
      go(4'd5, 1'b1, 1'b0);  chk_all("t4.c5", 5, 1, 0, 0);
      tick();                chk_all("t4.c4", 4, 1, 0, 0);
      tick();                chk_all("t4.c3", 3, 1, 0, 0);
      pause = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();             chk_all("t4.hold", 3, 1, 0, 0);
      end
      start = 1'b1;
      pause = 1'b0; tick();  chk_all("t4.resume", 3, 1, 0, 0);
      start = 1'b0;
      tick();                chk_all("t4.r2", 2, 1, 0, 0);
      tick();                chk_all("t4.r1", 1, 1, 0, 0);
      tick();                chk_all("t4.r0", 0, 1, 1, 0);
      tick();                chk_all("t4.done", 0, 0, 0, 1);
      tick();                chk_all("t4.after", 0, 0, 0, 0);

      // 5: stop / start conflicts
      go(4'd5, 1'b1, 1'b0);
      tick(); tick(); tick();
                             chk_all("t5.c2", 2, 1, 0, 0);
      stop = 1'b1; tick(); stop = 1'b0;
                             chk_all("t5.stop", 0, 0, 0, 0);
      tick();                chk_all("t5.nodone", 0, 0, 0, 0);
      stop = 1'b1; start = 1'b1; load_val = 4'd7;
      tick(); stop = 1'b0; start = 1'b0;
                             chk_all("t5.both", 0, 0, 0, 0);
      go(4'd10, 1'b0, 1'b0); chk_all("t5.run", 10, 1, 0, 0);
      load_val = 4'd2; dir = 1'b1; start = 1'b1;
      tick(); start = 1'b0;  chk_all("t5.ign", 11, 1, 0, 0);
      tick();                chk_all("t5.ign2", 12, 1, 0, 0);
      stop = 1'b1; tick(); stop = 1'b0;
      go(4'd14, 1'b0, 1'b0); chk_all("t5.t14", 14, 1, 0, 0);
      tick();                chk_all("t5.t15", 15, 1, 1, 0);
      stop = 1'b1; tick(); stop = 1'b0;
                             chk_all("t5.stoptc", 0, 0, 0, 0);
      tick();                chk_all("t5.stoptc2", 0, 0, 0, 0);

      // 6: edge load values
      go(4'd0, 1'b1, 1'b0);  chk_all("t6.z0", 0, 1, 1, 0);
      tick();                chk_all("t6.z1", 0, 0, 0, 1);
      tick();                chk_all("t6.z2", 0, 0, 0, 0);
      go(4'd15, 1'b0, 1'b1); chk_all("t6.f0", 15, 1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         tick();             chk_all("t6.fn", 15, 1, 1, 1);
      end
      stop = 1'b1; tick(); stop = 1'b0;
                             chk_all("t6.stop", 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_counter_seq_ctrl
